// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential stepping plus a request/wait handshake
// with an external jump-target unit for j, jal and jr.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        jump,
  input  logic [3:0]  path_index,
  input  logic [25:0] addr,
  input  logic [31:0] reg_addr,
  output logic        jmp_en,
  output logic [31:0] jmp_pc_o,
  output logic [25:0] jmp_addr_o,
  output logic [3:0]  jmp_path_o,
  output logic [31:0] jmp_reg_o,
  input  logic        jmp_done,
  input  logic [31:0] jmp_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        busy,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        timeout_err,
  output logic        align_err,
  output logic [1:0]  fsm_state
);

  // Handshake: jmp_en is a one-cycle strobe issued in REQ; jmp_done is a level
  // from the jump-target unit, honoured in any WAIT cycle (even if already high
  // before the request), with jmp_target sampled in the same cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  localparam logic [3:0] PATH_J   = 4'd5;
  localparam logic [3:0] PATH_JAL = 4'd6;
  localparam logic [3:0] PATH_JR  = 4'd8;
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] target;
  logic        qualify;
  logic [31:0] ret_addr;

  assign qualify   = jump && (path_index == PATH_J || path_index == PATH_JAL ||
                              path_index == PATH_JR);
  assign ret_addr  = jmp_pc_o + 32'd4;
  assign pc_valid  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      jmp_en      <= 1'b0;
      link_we     <= 1'b0;
      timeout_err <= 1'b0;
      align_err   <= 1'b0;
      wait_cnt    <= 8'd0;
      target      <= 32'd0;
      jmp_pc_o    <= 32'd0;
      jmp_addr_o  <= 26'd0;
      jmp_path_o  <= 4'd0;
      jmp_reg_o   <= 32'd0;
      link_data   <= 32'd0;
    end else begin
      jmp_en  <= 1'b0;
      link_we <= 1'b0;
      case (state)
        IDLE: begin
          if (step) begin
            if (qualify) begin
              jmp_pc_o   <= pc;
              jmp_addr_o <= addr;
              jmp_path_o <= path_index;
              jmp_reg_o  <= reg_addr;
              jmp_en     <= 1'b1;
              state      <= REQ;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        REQ: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (jmp_done || wait_cnt == LAST_CNT) begin
            // An abandoned request falls through to the next sequential pc.
            target <= jmp_done ? jmp_target : ret_addr;
            if (!jmp_done) timeout_err <= 1'b1;
            if (jmp_path_o == PATH_JAL) begin
              link_we   <= 1'b1;
              link_data <= ret_addr;
            end
            state <= UPDATE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        UPDATE: begin
          pc <= {target[31:2], 2'b00};
          if (target[1:0] != 2'b00) align_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stepping, j/jal/jr requests against a
// bench-driven jump-target stub, timeout, misalignment and reset mid-request.
module tb_pc_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        jump;
  logic [3:0]  path_index;
  logic [25:0] addr;
  logic [31:0] reg_addr;
  logic        jmp_en;
  logic [31:0] jmp_pc_o;
  logic [25:0] jmp_addr_o;
  logic [3:0]  jmp_path_o;
  logic [31:0] jmp_reg_o;
  logic        jmp_done;
  logic [31:0] jmp_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        busy;
  logic        link_we;
  logic [31:0] link_data;
  logic        timeout_err;
  logic        align_err;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Results captured by do_jump
  int          en_cnt, lw_cnt, lat;
  logic [31:0] lw_data, cap_pc, cap_reg;
  logic [25:0] cap_addr;
  logic [3:0]  cap_path;
  logic        busy_in_req;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .step(step), .jump(jump), .path_index(path_index),
    .addr(addr), .reg_addr(reg_addr), .jmp_en(jmp_en), .jmp_pc_o(jmp_pc_o),
    .jmp_addr_o(jmp_addr_o), .jmp_path_o(jmp_path_o), .jmp_reg_o(jmp_reg_o),
    .jmp_done(jmp_done), .jmp_target(jmp_target), .pc(pc), .pc_valid(pc_valid),
    .busy(busy), .link_we(link_we), .link_data(link_data),
    .timeout_err(timeout_err), .align_err(align_err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one jump at a negedge in IDLE; the stub raises jmp_done `delay`
  // cycles after the jmp_en cycle (never when give_done is 0).
  task automatic do_jump(input logic [3:0] path, input logic [25:0] a,
                         input logic [31:0] r, input logic [31:0] tgt,
                         input int delay, input bit give_done);
    int since;
    step = 1'b1; jump = 1'b1; path_index = path; addr = a; reg_addr = r;
    @(negedge clk);
    step = 1'b0; jump = 1'b0;
    en_cnt = 0; lw_cnt = 0; lw_data = 'x; lat = 0; since = -1;
    cap_pc = jmp_pc_o; cap_addr = jmp_addr_o; cap_path = jmp_path_o;
    cap_reg = jmp_reg_o; busy_in_req = busy;
    while (lat < 100) begin
      if (jmp_en) begin en_cnt++; since = 0; end
      else if (since >= 0) since++;
      if (give_done && since >= delay) begin jmp_done = 1'b1; jmp_target = tgt; end
      if (link_we) begin lw_cnt++; lw_data = link_data; end
      if (pc_valid) break;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("jump_timeout_bound", 32'(lat), 32'd0);
    jmp_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; jump = 1'b0; path_index = 4'd0; addr = 26'd0;
    reg_addr = 32'd0; jmp_done = 1'b0; jmp_target = 32'd0;
    repeat (2) @(negedge clk);

    check("rst_pc", pc, 32'h0);
    check("rst_pc_valid", 32'(pc_valid), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_jmp_en", 32'(jmp_en), 32'd0);
    check("rst_link_we", 32'(link_we), 32'd0);
    check("rst_errs", {30'd0, timeout_err, align_err}, 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);

    // Sequential stepping, first step right after reset release
    rst = 1'b0; step = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("step_pc_%0d", i), pc, 32'(4 * i));
      check("step_pc_valid", 32'(pc_valid), 32'd1);
      check("step_jmp_en", 32'(jmp_en), 32'd0);
    end
    // Jump flag with a non-jump path is just a step
    jump = 1'b1; path_index = 4'd7;
    @(negedge clk);
    step = 1'b0; jump = 1'b0;
    check("nonq_pc", pc, 32'h10);
    check("nonq_state", 32'(fsm_state), 32'd0);
    // step=0 holds pc
    @(negedge clk);
    check("hold_pc", pc, 32'h10);

    // Done already high: minimum latency; used to move pc to 1000_0010
    do_jump(4'd5, 26'd0, 32'd0, 32'h1000_0010, 0, 1'b1);
    check("fast_pc", pc, 32'h1000_0010);
    check("fast_latency", 32'(lat), 32'd3);
    check("fast_cap_pc", cap_pc, 32'h10);
    check("fast_busy_req", 32'(busy_in_req), 32'd1);

    // j
    do_jump(4'd5, 26'h0000040, 32'hDEAD_BEEF, 32'h1000_0100, 3, 1'b1);
    check("j_en_pulses", 32'(en_cnt), 32'd1);
    check("j_pc", pc, 32'h1000_0100);
    check("j_link_we", 32'(lw_cnt), 32'd0);
    check("j_cap_pc", cap_pc, 32'h1000_0010);
    check("j_cap_addr", 32'(cap_addr), 32'h40);
    check("j_cap_path", 32'(cap_path), 32'd5);
    check("j_cap_reg", cap_reg, 32'hDEAD_BEEF);

    // jal from 0x20
    do_jump(4'd5, 26'd0, 32'd0, 32'h0000_0020, 0, 1'b1);
    check("jal_setup_pc", pc, 32'h20);
    do_jump(4'd6, 26'h0000100, 32'd0, 32'h0000_0400, 1, 1'b1);
    check("jal_link_pulses", 32'(lw_cnt), 32'd1);
    check("jal_link_data", lw_data, 32'h24);
    check("jal_pc", pc, 32'h400);
    repeat (2) @(negedge clk);
    check("jal_link_hold", link_data, 32'h24);
    check("jal_link_we_low", 32'(link_we), 32'd0);

    // jr timeout
    do_jump(4'd8, 26'd0, 32'h0000_1234, 32'h0, 0, 1'b0);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_pc", pc, 32'h404);
    check("to_align", 32'(align_err), 32'd0);
    check("to_cap_reg", cap_reg, 32'h1234);
    check("to_lat_min", 32'(lat >= TIMEOUT), 32'd1);
    check("to_lat_max", 32'(lat <= TIMEOUT + 3), 32'd1);
    check("to_en_pulses", 32'(en_cnt), 32'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("to_next_step", pc, 32'h408);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Misaligned jr target
    do_jump(4'd8, 26'd0, 32'h0000_0103, 32'h0000_0103, 2, 1'b1);
    check("mis_pc", pc, 32'h100);
    check("mis_align", 32'(align_err), 32'd1);
    check("mis_link_we", 32'(lw_cnt), 32'd0);

    // Wrap-around of pc+4
    do_jump(4'd5, 26'd0, 32'd0, 32'hFFFF_FFFC, 0, 1'b1);
    check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("wrap_pc", pc, 32'h0);

    // Reset during WAIT; late done must be ignored
    step = 1'b1; jump = 1'b1; path_index = 4'd8; reg_addr = 32'h40;
    repeat (3) @(negedge clk);
    step = 1'b0; jump = 1'b0;
    check("rw_in_wait", 32'(fsm_state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw_state", 32'(fsm_state), 32'd0);
    check("rw_pc", pc, 32'h0);
    check("rw_jmp_en", 32'(jmp_en), 32'd0);
    check("rw_errs", {30'd0, timeout_err, align_err}, 32'd0);
    check("rw_jmp_ops", jmp_pc_o | jmp_reg_o | 32'(jmp_addr_o) | 32'(jmp_path_o), 32'd0);
    check("rw_link_data", link_data, 32'd0);
    jmp_done = 1'b1; jmp_target = 32'h500;
    repeat (3) @(negedge clk);
    jmp_done = 1'b0;
    check("rw_late_done_pc", pc, 32'h0);
    check("rw_late_done_valid", 32'(pc_valid), 32'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("rw_step", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall set the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, shall set the maximum number of WAIT cycles before the jump request is abandoned; the legal range is 2..255.
REQ-003 Port clk, input, 1 bit, shall be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, shall be a synchronous, active-high reset.
REQ-005 Port step, input, 1 bit, shall request advance by one instruction; sampled only in IDLE.
REQ-006 Port jump, input, 1 bit, shall carry the decoder jump flag.
REQ-007 Port path_index, input, 4 bits, shall carry the decoder path code: 5 = j, 6 = jal, 8 = jr.
REQ-008 Port addr, input, 26 bits, shall carry the J-type target field.
REQ-009 Port reg_addr, input, 32 bits, shall carry the register-file value for jr.
REQ-010 Port jmp_en, output, 1 bit, shall be the request strobe to the jump-target unit.
REQ-011 Port jmp_pc_o, jmp_addr_o, jmp_path_o, jmp_reg_o, outputs, 32/26/4/32 bits, shall carry the latched operands presented to the jump-target unit.
REQ-012 Port jmp_done, input, 1 bit, shall be the level completion flag from the jump-target unit.
REQ-013 Port jmp_target, input, 32 bits, shall carry the computed target from the jump-target unit.
REQ-014 Port pc, output, 32 bits, shall present the current program counter.
REQ-015 Port pc_valid, output, 1 bit, shall be high only in IDLE.
REQ-016 Port busy, output, 1 bit, shall be high in any state other than IDLE.
REQ-017 Port link_we, output, 1 bit, shall be the one-cycle $ra write strobe.
REQ-018 Port link_data, output, 32 bits, shall carry the return address.
REQ-019 Port timeout_err and align_err, outputs, 1 bit each, shall be sticky error flags.

Function
REQ-020 The FSM shall have four states: IDLE, REQ, WAIT, UPDATE.
REQ-021 In IDLE with step=1, a qualifying jump (jump=1 and path_index in {5,6,8}) shall latch pc, addr, path_index and reg_addr onto the jmp_*_o ports and go to REQ.
REQ-022 In IDLE with step=1 and no qualifying jump, pc shall become pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) on the next edge; the FSM shall stay in IDLE.
REQ-023 In IDLE with step=0, pc shall hold.
REQ-024 step shall be ignored in REQ, WAIT and UPDATE.
REQ-025 In REQ, jmp_en shall be 1 for exactly one cycle; the next state shall be WAIT with the wait counter set to 0.
REQ-026 jmp_en shall be 0 in every state other than REQ, which gives a clean rising edge per request.
REQ-027 In WAIT, the counter shall increment each cycle, and jmp_done=1 shall capture jmp_target into the target register and go to UPDATE.
REQ-028 A jmp_done that was already high before REQ is acceptable; it shall be honoured from the first WAIT cycle, giving a minimum request-to-UPDATE latency of 2 cycles.
REQ-029 If the counter reaches TIMEOUT-1 without jmp_done, timeout_err shall be set, the target shall be the latched pc+4, and the FSM shall go to UPDATE.
REQ-030 In UPDATE, pc shall load the target with bits [1:0] forced to 00; align_err shall be set if the captured bits [1:0] were not 00.
REQ-031 In UPDATE with latched path 6, link_we shall be 1 for that cycle, with link_data = latched pc+4.
REQ-032 In UPDATE with any other path, link_we shall be 0.
REQ-033 UPDATE shall always return to IDLE after one cycle.
REQ-034 link_data shall hold its last value when link_we=0.

Reset
REQ-035 While rst=1 at a clock edge, the following shall take effect on that edge, overriding all other activity, including mid-REQ/WAIT/UPDATE:
- state = IDLE, pc = RESET_PC
- jmp_en = 0, link_we = 0
- timeout_err = 0, align_err = 0
- wait counter = 0, target register = 0
- all jmp_*_o = 0, link_data = 0
- pc_valid = 1, busy = 0
REQ-036 The first step shall be accepted on the first edge after rst falls.

Verification
REQ-037 Sequential step: reset; step for 3 cycles with jump=0 -> pc = 4, 8, 12; pc_valid stays 1; jmp_en never asserts.
REQ-038 j: pc=32'h1000_0010, step, jump=1, path 5, addr=26'h0000040; stub returns done after 3 cycles with 32'h1000_0100 -> jmp_en pulses exactly one cycle; pc = 32'h1000_0100; link_we = 0.
REQ-039 jal: pc=32'h0000_0020, path 6, stub target 32'h0000_0400 -> link_we pulses once with link_data = 32'h0000_0024; pc = 32'h0000_0400.
REQ-040 jr timeout: path 8, jmp_done held 0 -> after TIMEOUT-1 WAIT cycles, timeout_err = 1 and pc = old pc+4; a subsequent step proceeds normally.
REQ-041 Misaligned target: jr with stub target 32'h0000_0103 -> pc = 32'h0000_0100; align_err = 1.
REQ-042 Reset in WAIT: assert rst for one cycle during WAIT -> next cycle state IDLE, pc = RESET_PC, jmp_en = 0, errors cleared; a late jmp_done is ignored.
